// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures the operands and the opcode. Stage 2 captures the result
// and the status flags, which are computed combinationally from stage 1.
// The pipeline holds at most two beats and sustains one beat per cycle.
//
// Parameters
//   NB_DATA    operand/result width in bits (>= 4)
//   NB_OPCODE  opcode width; only the low 6 bits encode operations, and any
//              set upper bit makes the opcode illegal
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   dato_a     operand A
//   dato_b     operand B, or the shift amount for SRL/SRA
//   opcode     operation select
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out        result
//   flag_z     result == 0 (legal opcodes only)
//   flag_n     result MSB
//   flag_c     ADD carry-out / SUB borrow
//   flag_v     signed overflow of ADD/SUB
//   flag_err   illegal opcode
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NB_DATA-1:0]   dato_a,
    input  logic [NB_DATA-1:0]   dato_b,
    input  logic [NB_OPCODE-1:0] opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NB_DATA-1:0]   out,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 flag_err
);

    localparam int MSB = NB_DATA - 1;

    typedef enum logic [5:0] {
        OP_SRL = 6'b000010,
        OP_SRA = 6'b000011,
        OP_ADD = 6'b100000,
        OP_SUB = 6'b100010,
        OP_AND = 6'b100100,
        OP_OR  = 6'b100101,
        OP_XOR = 6'b100110,
        OP_NOR = 6'b100111
    } op_e;

    // Stage 1 state
    logic                 s1_valid;
    logic [NB_DATA-1:0]   s1_a;
    logic [NB_DATA-1:0]   s1_b;
    logic [NB_OPCODE-1:0] s1_op;

    // Handshake control
    logic s1_adv;
    logic s2_adv;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    // in_ready looks only at pipeline state and out_ready, never at in_valid,
    // so upstream may wait for it without a combinational loop.
    assign in_ready = !s1_valid || s2_adv;
    assign s1_adv   = in_valid && in_ready;

    // Stage 2 combinational datapath
    logic [NB_DATA:0]   sum;
    logic [NB_DATA:0]   diff;
    logic [5:0]         op_lo;
    logic               upper_zero;
    logic               legal;
    logic [NB_DATA-1:0] res;
    logic               res_c;
    logic               res_v;

    assign sum        = {1'b0, s1_a} + {1'b0, s1_b};
    // The extra top bit of the difference is the unsigned borrow (a < b).
    assign diff       = {1'b0, s1_a} - {1'b0, s1_b};
    assign op_lo      = s1_op[5:0];
    assign upper_zero = (s1_op >> 6) == '0;

    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        legal = upper_zero;
        case (op_lo)
            OP_ADD: begin
                res   = sum[MSB:0];
                res_c = sum[NB_DATA];
                // Overflow: operands share a sign that the result does not.
                res_v = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                res   = diff[MSB:0];
                res_c = diff[NB_DATA];
                // Overflow: operand signs differ and the result flips A's sign.
                res_v = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
            end
            OP_AND: res = s1_a & s1_b;
            OP_OR:  res = s1_a | s1_b;
            OP_XOR: res = s1_a ^ s1_b;
            OP_NOR: res = ~(s1_a | s1_b);
            // Shifts by the full width of dato_b: amounts >= NB_DATA naturally
            // yield all zeros (SRL) or all copies of the sign bit (SRA).
            OP_SRL: res = s1_a >> s1_b;
            OP_SRA: res = $unsigned($signed(s1_a) >>> s1_b);
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            res   = '0;
            res_c = 1'b0;
            res_v = 1'b0;
        end
    end

    // Stage 1 payload. NOTE: data registers are not reset; s1_valid qualifies
    // them, so their power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (s1_adv) begin
            s1_a  <= dato_a;
            s1_b  <= dato_b;
            s1_op <= opcode;
        end
    end

    // Valid bits and stage 2 result. NOTE: sequential state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_err  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid <= 1'b1;
                out       <= res;
                flag_z    <= legal && (res == '0);
                flag_n    <= res[MSB];
                flag_c    <= res_c;
                flag_v    <= res_v;
                flag_err  <= !legal;
            end else if (out_ready) begin
                // Result taken with nothing behind it; out and flags keep
                // their last value.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;

    logic [5:0] legal_ops [8] = '{OP_SRL, OP_SRA, OP_ADD, OP_SUB,
                                  OP_AND, OP_OR, OP_XOR, OP_NOR};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 8-bit instance
    logic       iv8, ir8, ov8, or8;
    logic [7:0] a8, b8, o8;
    logic [5:0] op8;
    logic       z8, n8, c8, v8, e8;

    // 16-bit instance
    logic        iv16, ir16, ov16, or16;
    logic [15:0] a16, b16, o16;
    logic [5:0]  op16;
    logic        z16, n16, c16, v16, e16;

    alu_pipe #(.NB_DATA(8), .NB_OPCODE(6)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(iv8), .in_ready(ir8),
        .dato_a(a8), .dato_b(b8), .opcode(op8),
        .out_valid(ov8), .out_ready(or8), .out(o8),
        .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8), .flag_err(e8)
    );

    alu_pipe #(.NB_DATA(16), .NB_OPCODE(6)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(iv16), .in_ready(ir16),
        .dato_a(a16), .dato_b(b16), .opcode(op16),
        .out_valid(ov16), .out_ready(or16), .out(o16),
        .flag_z(z16), .flag_n(n16), .flag_c(c16), .flag_v(v16), .flag_err(e16)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] q8  [$];
    logic [63:0] q16 [$];

    // Result word layout: out in [15:0], flags {err,v,c,n,z} in [20:16].
    function automatic logic [63:0] pack(input longint o, input bit z, input bit n,
                                         input bit c, input bit v, input bit e);
        logic [63:0] ov;
        ov = o;
        return {43'b0, e, v, c, n, z, ov[15:0]};
    endfunction

    function automatic logic [63:0] obs8();
        return {43'b0, e8, v8, c8, n8, z8, 8'b0, o8};
    endfunction

    function automatic logic [63:0] obs16();
        return {43'b0, e16, v16, c16, n16, z16, o16};
    endfunction

    // Reference model on plain integers: signed views of the operands,
    // wide arithmetic, then masking back to w bits.
    function automatic logic [63:0] ref_model(input int w, input longint a,
                                              input longint b, input logic [5:0] op);
        longint m, half, sa, sb, r, sr;
        bit c, v, e;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (m + 1) : a;
        sb   = (b >= half) ? b - (m + 1) : b;
        r = 0; c = 0; v = 0; e = 0;
        case (op)
            OP_ADD: begin
                r  = (a + b) & m;
                c  = (a + b) > m;
                sr = sa + sb;
                v  = (sr >= half) || (sr < -half);
            end
            OP_SUB: begin
                r  = (a - b) & m;
                c  = a < b;
                sr = sa - sb;
                v  = (sr >= half) || (sr < -half);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b) & m;
            OP_SRL: r = (b >= w) ? 0 : (a >> b);
            OP_SRA: begin
                sr = (b >= w) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
                r  = sr & m;
            end
            default: e = 1;
        endcase
        return pack(r, !e && (r == 0), (r & half) != 0, c, v, e);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, let the combinational
    // in_ready settle, score outputs held since the last rising edge, and
    // record any beat about to be accepted.
    task automatic tick(input logic v8_i, input logic [7:0] xa8, input logic [7:0] xb8,
                        input logic [5:0] xop8, input logic r8_i,
                        input logic v16_i, input logic [15:0] xa16, input logic [15:0] xb16,
                        input logic [5:0] xop16, input logic r16_i);
        @(negedge clk);
        iv8  = v8_i;  a8  = xa8;  b8  = xb8;  op8  = xop8;  or8  = r8_i;
        iv16 = v16_i; a16 = xa16; b16 = xb16; op16 = xop16; or16 = r16_i;
        #1;
        if (ov8) begin
            check("sb8_pending", 64'(q8.size() != 0), 64'd1);
            if (q8.size() != 0) begin
                check("sb8_result", obs8(), q8[0]);
                if (or8) void'(q8.pop_front());
            end
        end
        if (ov16) begin
            check("sb16_pending", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) begin
                check("sb16_result", obs16(), q16[0]);
                if (or16) void'(q16.pop_front());
            end
        end
        if (iv8 && ir8)   q8.push_back(ref_model(8, longint'(a8), longint'(b8), op8));
        if (iv16 && ir16) q16.push_back(ref_model(16, longint'(a16), longint'(b16), op16));
    endtask

    task automatic tick8(input logic v, input logic [7:0] xa, input logic [7:0] xb,
                         input logic [5:0] xop, input logic r);
        tick(v, xa, xb, xop, r, 1'b0, 16'h0, 16'h0, 6'h0, 1'b1);
    endtask

    function automatic logic [5:0] rand_op();
        if ($urandom % 5 == 0) return 6'($urandom);
        return legal_ops[$urandom % 8];
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs [11];
    logic [7:0]  got  [$];
    int          idx;
    logic        beat;
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, pack(8'h80, 0, 1, 0, 1, 0)};
        vecs[1]  = '{OP_SUB, 8'h00, 8'h01, pack(8'hFF, 0, 1, 1, 0, 0)};
        vecs[2]  = '{OP_SUB, 8'h80, 8'h01, pack(8'h7F, 0, 0, 0, 1, 0)};
        vecs[3]  = '{OP_ADD, 8'hFF, 8'h01, pack(8'h00, 1, 0, 1, 0, 0)};
        vecs[4]  = '{OP_SRA, 8'h80, 8'h03, pack(8'hF0, 0, 1, 0, 0, 0)};
        vecs[5]  = '{OP_SRL, 8'h80, 8'h03, pack(8'h10, 0, 0, 0, 0, 0)};
        vecs[6]  = '{OP_SRA, 8'h80, 8'h09, pack(8'hFF, 0, 1, 0, 0, 0)};
        vecs[7]  = '{OP_SRL, 8'h80, 8'hC8, pack(8'h00, 1, 0, 0, 0, 0)};
        vecs[8]  = '{OP_NOR, 8'h0F, 8'hF0, pack(8'h00, 1, 0, 0, 0, 0)};
        vecs[9]  = '{6'b111111, 8'h12, 8'h34, pack(8'h00, 0, 0, 0, 0, 1)};
        vecs[10] = '{OP_ADD, 8'h01, 8'h01, pack(8'h02, 0, 0, 0, 0, 0)};

        // Reset state
        reset = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 1;
        iv16 = 0; a16 = 0; b16 = 0; op16 = 0; or16 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_out_flags", obs8(), 64'd0);
        check("rst_out_valid16", 64'(ov16), 64'd0);
        check("rst_out_flags16", obs16(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(ir8), 64'd1);

        // Directed vectors with two-edge latency
        foreach (vecs[i]) begin
            tick8(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            check($sformatf("vec%0d_accept", i), 64'(ir8), 64'd1);
            tick8(1'b0, 8'h0, 8'h0, 6'h0, 1'b1);
            check($sformatf("vec%0d_valid_edge1", i), 64'(ov8), 64'd0);
            tick8(1'b0, 8'h0, 8'h0, 6'h0, 1'b1);
            check($sformatf("vec%0d_valid_edge2", i), 64'(ov8), 64'd1);
            check($sformatf("vec%0d_result", i), obs8(), vecs[i].exp);
        end
        tick8(1'b0, 8'h0, 8'h0, 6'h0, 1'b1);

        // Streaming under backpressure: out_ready low for the first 3 cycles
        idx = 0;
        got.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            beat = idx < 4;
            tick8(beat, 8'(idx + 1), 8'(idx + 1), OP_ADD, cyc >= 3);
            if (cyc == 2) check("stream_in_ready_full", 64'(ir8), 64'd0);
            if (beat && ir8) idx++;
            if (ov8 && or8) got.push_back(o8);
            if (got.size() == 4) break;
        end
        check("stream_count", 64'(got.size()), 64'd4);
        foreach (got[i]) check($sformatf("stream_out%0d", i), 64'(got[i]), 64'(2 * (i + 1)));
        tick8(1'b0, 8'h0, 8'h0, 6'h0, 1'b1);

        // Reset with two beats in flight
        tick8(1'b1, 8'h05, 8'h06, OP_ADD, 1'b0);
        check("rstmid_accept0", 64'(ir8), 64'd1);
        tick8(1'b1, 8'h07, 8'h08, OP_ADD, 1'b0);
        check("rstmid_accept1", 64'(ir8), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_out_valid", 64'(ov8), 64'd0);
        q8.delete();
        q16.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstmid_in_ready", 64'(ir8), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick8(1'b0, 8'h0, 8'h0, 6'h0, 1'b1);
            check($sformatf("rstmid_no_stale%0d", i), 64'(ov8), 64'd0);
        end

        // Random traffic on both widths against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ra8  = 8'($urandom);
            rb8  = ($urandom % 2 == 0) ? 8'($urandom % 10) : 8'($urandom);
            ra16 = 16'($urandom);
            rb16 = ($urandom % 2 == 0) ? 16'($urandom % 18) : 16'($urandom);
            tick(($urandom % 4) != 0, ra8, rb8, rand_op(), ($urandom % 3) != 0,
                 ($urandom % 4) != 0, ra16, rb16, rand_op(), ($urandom % 3) != 0);
        end
        for (int i = 0; i < 50; i++) begin
            if (q8.size() == 0 && q16.size() == 0) break;
            tick(1'b0, 8'h0, 8'h0, 6'h0, 1'b1, 1'b0, 16'h0, 16'h0, 6'h0, 1'b1);
        end
        check("drain8_empty", 64'(q8.size()), 64'd0);
        check("drain16_empty", 64'(q16.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
